// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte bus of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  // receiver side: consumes the line, produces the byte strobe
  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  // consumer side: drives the line, observes the received bytes
  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with two-flop input synchroniser
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_rx_if.master  bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sr_q, sr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  // next-state logic: synchroniser shift, bit timing and frame decoding
  always_comb begin
    sync1_d     = bus.rx;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end else begin
            // line went back high before mid start bit: treat as a glitch
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_TC) begin
          cnt_d = '0;
          sr_d  = {rx_s_q, sr_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_TC) begin
          cnt_d = '0;
          if (rx_s_q) begin
            rx_data_d  = sr_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_IDLE: begin
        // hold off until the line returns high so a break is not read as data
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      sr_q        <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;
  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] v_data[$];
  int         v_cyc[$];
  int         e_cyc[$];
  int         both_cnt = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx_if u_if ();

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // observe output strobes away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.rx_valid) begin
        v_data.push_back(u_if.rx_data);
        v_cyc.push_back(cyc);
      end
      if (u_if.frame_err) e_cyc.push_back(cyc);
      if (u_if.rx_valid && u_if.frame_err) both_cnt++;
      if (u_if.busy) busy_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    v_data.delete();
    v_cyc.delete();
    e_cyc.delete();
    busy_seen = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, output int start);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = cyc;
      u_if.rx = bits[i];
      repeat (CPB - 1) @(posedge clk);
    end
  endtask

  task automatic expect_one_valid(input string name, input logic [7:0] d, input int start);
    checks++;
    if (v_data.size() !== 1) begin
      errors++;
      $display("FAIL %s valid_count got %0d exp 1", name, v_data.size());
    end else begin
      checks++;
      if (v_data[0] !== d) begin
        errors++;
        $display("FAIL %s data got %02h exp %02h", name, v_data[0], d);
      end
      checks++;
      if (v_cyc[0] !== start + LAT) begin
        errors++;
        $display("FAIL %s latency got %0d exp %0d", name, v_cyc[0] - start, LAT);
      end
    end
    checks++;
    if (e_cyc.size() !== 0) begin
      errors++;
      $display("FAIL %s frame_err_count got %0d exp 0", name, e_cyc.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 u_if.rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.busy} !== 11'h000) begin
        errors++;
        $display("FAIL reset_outputs got data=%02h v=%b e=%b b=%b exp 00/0/0/0",
                 u_if.rx_data, u_if.rx_valid, u_if.frame_err, u_if.busy);
      end
    end
    @(posedge clk);
    #1 u_if.rx = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (u_if.busy !== 1'b0 || u_if.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_release got busy=%b data=%02h exp 0/00", u_if.busy, u_if.rx_data);
    end
  endtask

  task automatic test_single();
    int s;
    clear_mon();
    drive_frame(8'hC9, 1'b1, s);
    repeat (20) @(posedge clk);
    @(negedge clk);
    expect_one_valid("single", 8'hC9, s);
    last_good = 8'hC9;
    checks++;
    if (u_if.rx_data !== 8'hC9) begin
      errors++;
      $display("FAIL single_hold got %02h exp c9", u_if.rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int starts [3];
    bytes = '{8'h0F, 8'hA5, 8'h00};
    clear_mon();
    for (int i = 0; i < 3; i++) drive_frame(bytes[i], 1'b1, starts[i]);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (v_data.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 3", v_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (v_data[i] !== bytes[i] || v_cyc[i] !== starts[i] + LAT) begin
          errors++;
          $display("FAIL b2b_frame%0d got %02h@%0d exp %02h@%0d", i, v_data[i],
                   v_cyc[i] - starts[0], bytes[i], starts[i] + LAT - starts[0]);
        end
      end
      checks++;
      if (v_cyc[2] - v_cyc[1] !== 10 * CPB) begin
        errors++;
        $display("FAIL b2b_spacing got %0d exp %0d", v_cyc[2] - v_cyc[1], 10 * CPB);
      end
    end
    last_good = 8'h00;
  endtask

  task automatic test_glitch();
    clear_mon();
    @(posedge clk);
    #1 u_if.rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 u_if.rx = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_seen !== 1'b1 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy got seen=%b now=%b exp 1/0", busy_seen, u_if.busy);
    end
    checks++;
    if (v_data.size() + e_cyc.size() !== 0) begin
      errors++;
      $display("FAIL glitch_outputs got %0d strobes exp 0", v_data.size() + e_cyc.size());
    end
  endtask

  task automatic test_frame_err();
    int s;
    int bad;
    clear_mon();
    bad = 0;
    drive_frame(8'h55, 1'b0, s);
    repeat (30) begin
      @(negedge clk);
      if (u_if.busy !== 1'b1) bad++;
    end
    @(posedge clk);
    #1 u_if.rx = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (e_cyc.size() !== 1 || (e_cyc.size() == 1 && e_cyc[0] !== s + LAT)) begin
      errors++;
      $display("FAIL ferr_pulse got count=%0d exp 1 at +%0d", e_cyc.size(), LAT);
    end
    checks++;
    if (v_data.size() !== 0 || u_if.rx_data !== last_good) begin
      errors++;
      $display("FAIL ferr_data got valids=%0d data=%02h exp 0/%02h",
               v_data.size(), u_if.rx_data, last_good);
    end
    checks++;
    if (bad !== 0 || u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy got low_cycles=%0d busy_after=%b exp 0/0", bad, u_if.busy);
    end
    clear_mon();
    drive_frame(8'h3C, 1'b1, s);
    repeat (20) @(posedge clk);
    @(negedge clk);
    expect_one_valid("ferr_recover", 8'h3C, s);
    last_good = 8'h3C;
  endtask

  task automatic test_reset_mid();
    int s;
    clear_mon();
    @(posedge clk);
    #1 u_if.rx = 1'b0;
    repeat (CPB - 1) @(posedge clk);
    @(posedge clk);
    #1 u_if.rx = 1'b1;
    repeat (4 * CPB + HALF) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (u_if.busy !== 1'b0 || u_if.rx_data !== 8'h00 || u_if.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got busy=%b data=%02h v=%b exp 0/00/0",
               u_if.busy, u_if.rx_data, u_if.rx_valid);
    end
    #1 rst_n = 1'b1;
    last_good = 8'h00;
    repeat (6 * CPB) @(posedge clk);
    @(negedge clk);
    checks++;
    if (v_data.size() + e_cyc.size() !== 0) begin
      errors++;
      $display("FAIL midreset_abort got %0d strobes exp 0", v_data.size() + e_cyc.size());
    end
    clear_mon();
    drive_frame(8'h81, 1'b1, s);
    repeat (20) @(posedge clk);
    @(negedge clk);
    expect_one_valid("midreset_next", 8'h81, s);
    last_good = 8'h81;
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    int         exp_c[$];
    logic [7:0] b;
    int         s;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      int gap;
      gap = $urandom_range(0, 12);
      if (gap > 0) repeat (gap) @(posedge clk);
      b = 8'($urandom);
      drive_frame(b, 1'b1, s);
      exp_d.push_back(b);
      exp_c.push_back(s + LAT);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (v_data.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL random_count got %0d exp %0d", v_data.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (v_data[i] !== exp_d[i] || v_cyc[i] !== exp_c[i]) begin
          errors++;
          $display("FAIL random_frame%0d got %02h@%0d exp %02h@%0d",
                   i, v_data[i], v_cyc[i], exp_d[i], exp_c[i]);
        end
      end
    end
    checks++;
    if (e_cyc.size() !== 0 || both_cnt !== 0) begin
      errors++;
      $display("FAIL random_err got ferr=%0d overlap=%0d exp 0/0", e_cyc.size(), both_cnt);
    end
  endtask

  initial begin
    u_if.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
